wb_stage: RTL

Writeback and state stage directly downstream of the 8-bit ALU. It holds the two architectural accumulators A and B and the C/Z/N flags, and feeds A and B back to the ALU operand inputs. It commits each accepted instruction's 9-bit ALU result, or memory load data, into the destination accumulator and flags. It also sequences the single-outstanding memory transaction for loads and stores, with a timeout on loads.

---
 rtl/wb_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - accumulator/flag writeback and single-outstanding memory sequencer
module wb_stage #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iValid,
   output logic       oReady,
   input  logic [5:0] iOpcode,
   input  logic [8:0] iAluOut,
   input  logic [7:0] iConst,
   output logic [7:0] oA,
   output logic [7:0] oB,
   output logic       oC,
   output logic       oZ,
   output logic       oN,
   output logic [7:0] oMemAddr,
   output logic [7:0] oMemWData,
   output logic       oMemWE,
   output logic       oMemRE,
   input  logic [7:0] iMemRData,
   input  logic       iMemRValid,
   output logic       oDone,
   output logic       oErr
);

   localparam logic [5:0] LDA   = 6'd0,  LDB   = 6'd1,  STA   = 6'd2,  STB   = 6'd3;
   localparam logic [5:0] ADDA  = 6'd4,  ADDB  = 6'd5,  ADDCA = 6'd6,  ADDCB = 6'd7;
   localparam logic [5:0] SUBA  = 6'd8,  SUBB  = 6'd9,  SUBCA = 6'd10, SUBCB = 6'd11;
   localparam logic [5:0] ANDA  = 6'd12, ANDB  = 6'd13, ANDCA = 6'd14, ANDCB = 6'd15;
   localparam logic [5:0] ORA   = 6'd16, ORB   = 6'd17, ORCA  = 6'd18, ORCB  = 6'd19;
   localparam logic [5:0] ASLA  = 6'd20, ASRA  = 6'd21, LDCA  = 6'd22, LDCB  = 6'd23;

   // cnt counts cycles elapsed since the read-strobe cycle; LAST is the final wait cycle
   localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, MEMRD, MEMWAIT, MEMWR} state_t;

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       ld_b, ld_b_nx;
   logic [7:0] a_nx, b_nx, addr_nx, wdata_nx;
   logic       c_nx, z_nx, n_nx, we_nx, re_nx, done_nx, err_nx;
   logic       is_alu, is_ld, is_st, dst_b, alu_carry;

   assign oReady = (state == IDLE);

   always_comb begin
      is_alu    = 1'b0;
      is_ld     = 1'b0;
      is_st     = 1'b0;
      dst_b     = 1'b0;
      alu_carry = 1'b0;
      case (iOpcode)
         ADDA, ADDCA, SUBA, SUBCA, ASLA: begin is_alu = 1'b1; alu_carry = 1'b1; end
         ADDB, ADDCB, SUBB, SUBCB:       begin is_alu = 1'b1; alu_carry = 1'b1; dst_b = 1'b1; end
         ANDA, ANDCA, ORA, ORCA, ASRA, LDCA: is_alu = 1'b1;
         ANDB, ANDCB, ORB, ORCB, LDCB:   begin is_alu = 1'b1; dst_b = 1'b1; end
         STA:                            is_st = 1'b1;
         STB:                            begin is_st = 1'b1; dst_b = 1'b1; end
         LDA:                            is_ld = 1'b1;
         LDB:                            begin is_ld = 1'b1; dst_b = 1'b1; end
         default:                        is_alu = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ld_b_nx  = ld_b;
      a_nx     = oA;
      b_nx     = oB;
      c_nx     = oC;
      z_nx     = oZ;
      n_nx     = oN;
      addr_nx  = oMemAddr;
      wdata_nx = oMemWData;
      we_nx    = 1'b0;
      re_nx    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = oErr;
      case (state)
         IDLE: begin
            if (iValid) begin
               if (is_alu) begin
                  if (dst_b) b_nx = iAluOut[7:0];
                  else       a_nx = iAluOut[7:0];
                  c_nx    = alu_carry ? iAluOut[8] : 1'b0;
                  z_nx    = (iAluOut[7:0] == 8'h00);
                  n_nx    = iAluOut[7];
                  done_nx = 1'b1;
               end else if (is_st) begin
                  addr_nx  = iConst;
                  wdata_nx = iAluOut[7:0];
                  state_nx = MEMWR;
               end else if (is_ld) begin
                  addr_nx  = iConst;
                  ld_b_nx  = dst_b;
                  re_nx    = 1'b1;
                  state_nx = MEMRD;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         MEMRD: begin
            cnt_nx = 8'd1;
            if (MEM_TIMEOUT == 1) begin
               err_nx   = 1'b1;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = MEMWAIT;
            end
         end
         MEMWAIT: begin
            // data arriving in the final wait cycle still beats the timeout
            if (iMemRValid) begin
               if (ld_b) b_nx = iMemRData;
               else      a_nx = iMemRData;
               z_nx     = (iMemRData == 8'h00);
               n_nx     = iMemRData[7];
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (cnt == LAST) begin
               err_nx   = 1'b1;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         MEMWR: begin
            we_nx    = 1'b1;
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         ld_b      <= 1'b0;
         oA        <= 8'd0;
         oB        <= 8'd0;
         oC        <= 1'b0;
         oZ        <= 1'b0;
         oN        <= 1'b0;
         oMemAddr  <= 8'd0;
         oMemWData <= 8'd0;
         oMemWE    <= 1'b0;
         oMemRE    <= 1'b0;
         oDone     <= 1'b0;
         oErr      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         ld_b      <= ld_b_nx;
         oA        <= a_nx;
         oB        <= b_nx;
         oC        <= c_nx;
         oZ        <= z_nx;
         oN        <= n_nx;
         oMemAddr  <= addr_nx;
         oMemWData <= wdata_nx;
         oMemWE    <= we_nx;
         oMemRE    <= re_nx;
         oDone     <= done_nx;
         oErr      <= err_nx;
      end
   end

endmodule
